// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Issues fetch requests at pc,
// advances pc by 4 on each handshake, and redirects on a jump or on an
// enabled branch. A redirect takes priority over a handshake in the same cycle.
// Optional feature macro: FETCH_CTRL_MISALIGN_TRAP_EN. When it is defined, a
// redirect to a target that is not word-aligned sets misalign and parks the
// sequencer in TRAP until reset.
module fetch_ctrl #(
  parameter logic [7:0]  RESET_ADDR = 8'h00,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             br_sig,
  input  logic             we,
  input  logic             j_pc,
  input  logic [7:0]       br_instruction,
  input  logic             imem_ready,
  output logic             imem_req,
  output logic [7:0]       imem_addr,
  output logic             instr_valid,
  output logic [7:0]       instr_pc,
  output logic [7:0]       ret_addr,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic             misalign
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] STALL = 2'd2;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
  localparam logic [1:0] TRAP  = 2'd3;
`endif

  logic [1:0] state;
  logic [7:0] pc;
  logic       redirect;
  logic       handshake;

  // Request, handshake and redirect decode from the current state and inputs.
  always_comb begin
    imem_req  = (state == REQ) && !stall;
    handshake = imem_req && imem_ready;
    redirect  = j_pc || (br_sig && we);
  end

  assign imem_addr = pc;
  assign ret_addr  = pc + 8'h04;

  // Sequencer state, pc, completion pulse and fetch counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_ADDR;
      instr_valid <= 1'b0;
      instr_pc    <= 8'h00;
      fetch_cnt   <= '0;
    end else begin
      instr_valid <= 1'b0;
      case (state)
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
        TRAP: state <= TRAP;
`endif
        IDLE, REQ, STALL: begin
          if (redirect) begin
            // Redirect discards any same-cycle handshake.
            pc    <= br_instruction;
            state <= stall ? STALL : REQ;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
            if (br_instruction[1:0] != 2'b00) state <= TRAP;
`endif
          end else begin
            if (handshake) begin
              pc          <= pc + 8'h04;
              instr_valid <= 1'b1;
              instr_pc    <= pc;
              fetch_cnt   <= fetch_cnt + CNT_W'(1);
            end
            // IDLE and STALL both resume into REQ once stall is low;
            // REQ falls back to STALL while stall is high.
            state <= stall ? STALL : REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
  // Sticky flag set by a redirect to a non-word-aligned target.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign <= 1'b0;
    end else if ((state != TRAP) && redirect && (br_instruction[1:0] != 2'b00)) begin
      misalign <= 1'b1;
    end
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl with a cycle-level reference
// model and hand-computed literal expectations along the stimulus sequence.
// Build with or without FETCH_CTRL_MISALIGN_TRAP_EN; expectations follow it.
module tb_fetch_ctrl;

  localparam int unsigned CW = 4;
  localparam logic [7:0]  RA = 8'h00;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall = 1'b0;
  logic          br_sig = 1'b0;
  logic          we = 1'b0;
  logic          j_pc = 1'b0;
  logic [7:0]    br_instruction = 8'h00;
  logic          imem_ready = 1'b1;
  logic          imem_req;
  logic [7:0]    imem_addr;
  logic          instr_valid;
  logic [7:0]    instr_pc;
  logic [7:0]    ret_addr;
  logic [CW-1:0] fetch_cnt;
  logic          misalign;

  fetch_ctrl #(.RESET_ADDR(RA), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_sig(br_sig), .we(we),
    .j_pc(j_pc), .br_instruction(br_instruction), .imem_ready(imem_ready),
    .imem_req(imem_req), .imem_addr(imem_addr), .instr_valid(instr_valid),
    .instr_pc(instr_pc), .ret_addr(ret_addr), .fetch_cnt(fetch_cnt),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic check_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: "active" means the fetcher wants to request next cycle,
  // which after any non-trapped cycle is simply "stall was low".
  typedef struct packed {
    logic [7:0]    pc;
    logic          active;
    logic          trap;
    logic          valid;
    logic [7:0]    ipc;
    logic [CW-1:0] cnt;
    logic          mis;
  } model_t;

  model_t m = '0;

  function automatic model_t model_next(input model_t c, input logic r, input logic st,
                                        input logic b, input logic w, input logic j,
                                        input logic [7:0] t, input logic rdy);
    model_t n = c;
    if (!r) begin
      n = '0;
      n.pc = RA;
    end else if (c.trap) begin
      n.valid = 1'b0;
    end else begin
      n.valid  = 1'b0;
      n.active = !st;
      if (j || (b && w)) begin
        n.pc = t;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
        if (t[1:0] != 2'b00) begin
          n.mis  = 1'b1;
          n.trap = 1'b1;
        end
`endif
      end else if (c.active && !st && rdy) begin
        n.ipc   = c.pc;
        n.pc    = c.pc + 8'd4;
        n.valid = 1'b1;
        n.cnt   = c.cnt + CW'(1);
      end
    end
    return n;
  endfunction

  always @(posedge clk)
    m <= model_next(m, rst_n, stall, br_sig, we, j_pc, br_instruction, imem_ready);

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("m_imem_req", 32'(imem_req), 32'(m.active && !stall && !m.trap));
      chk("m_imem_addr", 32'(imem_addr), 32'(m.pc));
      chk("m_ret_addr", 32'(ret_addr), 32'(8'(m.pc + 8'd4)));
      chk("m_instr_valid", 32'(instr_valid), 32'(m.valid));
      chk("m_instr_pc", 32'(instr_pc), 32'(m.ipc));
      chk("m_fetch_cnt", 32'(fetch_cnt), 32'(m.cnt));
      chk("m_misalign", 32'(misalign), 32'(m.mis));
    end
  end

  // Apply inputs just after a rising edge; return at the following falling edge.
  task automatic drive(input logic r, input logic st, input logic b, input logic w,
                       input logic j, input logic [7:0] t, input logic rdy);
    @(posedge clk);
    #1;
    rst_n = r; stall = st; br_sig = b; we = w; j_pc = j;
    br_instruction = t; imem_ready = rdy;
    @(negedge clk);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 8'h00, 1);
    check_en = 1'b1;
    // reset state
    drive(1, 0, 0, 0, 0, 8'h00, 1);
    chk("lit_rst_req", 32'(imem_req), 32'h0);
    chk("lit_rst_addr", 32'(imem_addr), 32'h00);
    chk("lit_rst_cnt", 32'(fetch_cnt), 32'h0);
    chk("lit_rst_valid", 32'(instr_valid), 32'h0);
    chk("lit_rst_mis", 32'(misalign), 32'h0);
    // first fetches
    drive(1, 0, 0, 0, 0, 8'h00, 1);
    chk("lit_first_req", 32'(imem_req), 32'h1);
    chk("lit_first_addr", 32'(imem_addr), 32'h00);
    drive(1, 0, 0, 0, 0, 8'h00, 1);
    chk("lit_f1_addr", 32'(imem_addr), 32'h04);
    chk("lit_f1_ipc", 32'(instr_pc), 32'h00);
    chk("lit_f1_valid", 32'(instr_valid), 32'h1);
    // jump requested while a handshake is also possible
    drive(1, 0, 0, 0, 1, 8'h40, 1);
    chk("lit_f2_addr", 32'(imem_addr), 32'h08);
    chk("lit_f2_ipc", 32'(instr_pc), 32'h04);
    chk("lit_f2_cnt", 32'(fetch_cnt), 32'h2);
    // branch without enable
    drive(1, 0, 1, 0, 0, 8'h80, 1);
    chk("lit_jmp_valid", 32'(instr_valid), 32'h0);
    chk("lit_jmp_addr", 32'(imem_addr), 32'h40);
    chk("lit_jmp_cnt", 32'(fetch_cnt), 32'h2);
    // branch with enable
    drive(1, 0, 1, 1, 0, 8'h80, 1);
    chk("lit_brnowe_addr", 32'(imem_addr), 32'h44);
    chk("lit_brnowe_cnt", 32'(fetch_cnt), 32'h3);
    // memory not ready
    drive(1, 0, 0, 0, 0, 8'h00, 0);
    chk("lit_br_addr", 32'(imem_addr), 32'h80);
    chk("lit_br_valid", 32'(instr_valid), 32'h0);
    drive(1, 0, 0, 0, 0, 8'h00, 0);
    chk("lit_nrdy_addr", 32'(imem_addr), 32'h80);
    chk("lit_nrdy_req", 32'(imem_req), 32'h1);
    // stall for three cycles
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 0, 8'h00, 1);
      chk("lit_stall_req", 32'(imem_req), 32'h0);
      chk("lit_stall_addr", 32'(imem_addr), 32'h80);
    end
    drive(1, 0, 0, 0, 0, 8'h00, 1);
    chk("lit_unstall_req", 32'(imem_req), 32'h0);
    drive(1, 0, 0, 0, 0, 8'h00, 1);
    chk("lit_resume_req", 32'(imem_req), 32'h1);
    chk("lit_resume_addr", 32'(imem_addr), 32'h80);
    // wrap of pc at 0xFC
    drive(1, 0, 0, 0, 1, 8'hF8, 1);
    chk("lit_resume_ipc", 32'(instr_pc), 32'h80);
    drive(1, 0, 0, 0, 0, 8'h00, 1);
    chk("lit_f8_ret", 32'(ret_addr), 32'hFC);
    drive(1, 0, 0, 0, 0, 8'h00, 1);
    chk("lit_fc_addr", 32'(imem_addr), 32'hFC);
    chk("lit_fc_ret", 32'(ret_addr), 32'h00);
    drive(1, 0, 0, 0, 0, 8'h00, 1);
    chk("lit_wrap_addr", 32'(imem_addr), 32'h00);
    chk("lit_wrap_ipc", 32'(instr_pc), 32'hFC);
    // reset beats a same-cycle jump and handshake
    drive(0, 0, 0, 0, 1, 8'h40, 1);
    drive(1, 0, 0, 0, 0, 8'h00, 1);
    chk("lit_rst2_addr", 32'(imem_addr), 32'(RA));
    chk("lit_rst2_cnt", 32'(fetch_cnt), 32'h0);
    chk("lit_rst2_valid", 32'(instr_valid), 32'h0);
    chk("lit_rst2_req", 32'(imem_req), 32'h0);
    // counter wrap: 16 handshakes with a 4-bit counter
    drive(1, 0, 0, 0, 0, 8'h00, 1);
    for (int i = 0; i < 16; i++) drive(1, 0, 0, 0, 0, 8'h00, 1);
    chk("lit_cntwrap_cnt", 32'(fetch_cnt), 32'h0);
    chk("lit_cntwrap_addr", 32'(imem_addr), 32'h40);
    chk("lit_cntwrap_ipc", 32'(instr_pc), 32'h3C);
    // misaligned redirect
    drive(1, 0, 0, 0, 1, 8'h42, 1);
    drive(1, 0, 0, 0, 0, 8'h00, 1);
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    chk("lit_trap_mis", 32'(misalign), 32'h1);
    chk("lit_trap_req", 32'(imem_req), 32'h0);
    chk("lit_trap_addr", 32'(imem_addr), 32'h42);
    drive(1, 0, 0, 0, 1, 8'h10, 1);
    drive(1, 0, 0, 0, 0, 8'h00, 1);
    chk("lit_trap_hold_req", 32'(imem_req), 32'h0);
    chk("lit_trap_hold_addr", 32'(imem_addr), 32'h42);
    chk("lit_trap_hold_valid", 32'(instr_valid), 32'h0);
`else
    chk("lit_mis_addr", 32'(imem_addr), 32'h42);
    chk("lit_mis_req", 32'(imem_req), 32'h1);
    drive(1, 0, 0, 0, 0, 8'h00, 1);
    chk("lit_mis_next_addr", 32'(imem_addr), 32'h46);
    chk("lit_mis_next_ipc", 32'(instr_pc), 32'h42);
    chk("lit_mis_flag", 32'(misalign), 32'h0);
`endif
    // reset, then hold stall across the IDLE exit
    drive(0, 0, 0, 0, 0, 8'h00, 1);
    drive(1, 1, 0, 0, 0, 8'h00, 1);
    chk("lit_rst3_mis", 32'(misalign), 32'h0);
    drive(1, 1, 0, 0, 0, 8'h00, 1);
    chk("lit_idlestall_req", 32'(imem_req), 32'h0);
    drive(1, 0, 0, 0, 0, 8'h00, 1);
    chk("lit_idlestall_req2", 32'(imem_req), 32'h0);
    drive(1, 0, 0, 0, 0, 8'h00, 1);
    chk("lit_idlestall_go", 32'(imem_req), 32'h1);
    chk("lit_idlestall_addr", 32'(imem_addr), 32'(RA));
    drive(1, 0, 0, 0, 0, 8'h00, 1);
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_ADDR, default 8'h00: fetch address loaded on reset.
REQ-002 Parameter CNT_W, default 16: width of the fetch-completion counter.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low; sampled on posedge clk only.
REQ-005 stall  input  1  downstream hold; suppresses new fetch requests.
REQ-006 br_sig  input  1  branch condition true.
REQ-007 we  input  1  branch enable; a branch redirect requires br_sig && we.
REQ-008 j_pc  input  1  unconditional jump redirect.
REQ-009 br_instruction  input  8  redirect target address.
REQ-010 imem_ready  input  1  instruction memory accepts the current request.
REQ-011 imem_req  output  1  fetch request to instruction memory.
REQ-012 imem_addr  output  8  fetch address; equals current pc.
REQ-013 instr_valid  output  1  one-cycle pulse: a fetch completed in the previous cycle.
REQ-014 instr_pc  output  8  address of the completed fetch; valid while instr_valid is high.
REQ-015 ret_addr  output  8  pc + 8'h04, combinational, modulo 256.
REQ-016 fetch_cnt  output  CNT_W  count of completed fetches.
REQ-017 misalign  output  1  sticky misaligned-redirect flag (macro-dependent, see Configuration).

Function
REQ-018 States: IDLE, REQ, STALL, and TRAP (TRAP exists only with the macro); state is held in one registered state variable.
REQ-019 imem_req = (state == REQ) && !stall, combinational; a handshake completes in any cycle where imem_req && imem_ready.
REQ-020 IDLE: go to REQ next cycle if stall is low, otherwise go to STALL; imem_req is 0.
REQ-021 REQ, handshake complete: pc <= pc + 4 (8-bit wrap, 8'hFC -> 8'h00); instr_valid <= 1; instr_pc <= pc; fetch_cnt increments; state stays REQ.
REQ-022 REQ, imem_ready low and stall low: pc and state hold, imem_req stays high, instr_valid <= 0.
REQ-023 REQ with stall high: state goes to STALL; no handshake occurs.
REQ-024 STALL: imem_req = 0; go to REQ the cycle after stall is sampled low.
REQ-025 Redirect = j_pc || (br_sig && we), evaluated in IDLE, REQ and STALL.
REQ-026 Redirect has priority over a same-cycle handshake: pc <= br_instruction; instr_valid <= 0; fetch_cnt does not increment; the fetch is discarded.
REQ-027 After a redirect, the next state is STALL if stall is high, otherwise REQ.
REQ-028 instr_valid is high for exactly one cycle per completed, non-redirected handshake.
REQ-029 fetch_cnt wraps from all-ones to 0 without a flag.
REQ-030 imem_addr = pc at all times.

Reset
REQ-031 When rst_n is low at posedge clk: state = IDLE, pc = RESET_ADDR, instr_valid = 0, instr_pc = 8'h00, fetch_cnt = 0, misalign = 0.
REQ-032 Reset overrides any redirect, stall or handshake in the same cycle, including reset asserted while in REQ with imem_ready high.
REQ-033 The first imem_req after reset release is asserted in the cycle after IDLE, with imem_addr = RESET_ADDR.

Configuration
REQ-034 Macro FETCH_CTRL_MISALIGN_TRAP_EN controls misaligned-redirect detection.
REQ-035 With the macro defined: a redirect with br_instruction[1:0] != 2'b00 sets misalign = 1, loads pc, and enters TRAP.
REQ-036 TRAP: imem_req = 0 and instr_valid = 0 permanently; only reset exits TRAP.
REQ-037 Without the macro: the TRAP state is absent; misalign is tied to 0; misaligned targets load pc unchanged and fetching continues.

Verification
REQ-038 Reset release, imem_ready = 1, stall = 0 -> imem_addr sequence 00, 04, 08; instr_valid pulses with instr_pc 00, 04; fetch_cnt = 2 after the second pulse.
REQ-039 pc = 8'hFC, handshake completes -> pc = 8'h00, ret_addr was 8'h00 while pc = 8'hFC.
REQ-040 In REQ with imem_ready = 1, assert j_pc with br_instruction = 8'h40 -> no instr_valid the next cycle, fetch_cnt unchanged, imem_addr = 8'h40.
REQ-041 br_sig = 1 with we = 0 -> no redirect; br_sig = 1 with we = 1 -> redirect taken.
REQ-042 stall high for 3 cycles mid-fetch -> imem_req = 0 for 3 cycles, pc held, fetching resumes at the same address one cycle after stall falls.
REQ-043 Macro defined, redirect to 8'h42 -> misalign = 1, imem_req stays 0 until rst_n is low; macro undefined -> imem_addr = 8'h42 and fetching continues.
